data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Responder side of the pipelined core's data-memory port. It sits outside the core and answers the core's memory-stage accesses with a data word every cycle. It serves a word-addressed data RAM plus a small memory-mapped I/O window: a GPIO output register, a 64-bit cycle counter, a periodic compare timer with an interrupt flag, and a sticky bus-error flag.

## Interface
Parameters:
- DEPTH, 1024: data RAM size in 32-bit words; power of two.
- GPIO_W, 8: width of the GPIO output register.

Ports:
- clock  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- ram_address  in  32  byte address from the core's EX/MEM register.
- ram_w_data  in  32  store data.
- read_write_ram_en  in  1  1 = write this cycle; 0 = read.
- ram_r_data  out  32  read data for ram_address, combinational, same cycle.
- gpio_out  out  GPIO_W  GPIO_OUT register.
- timer_irq  out  1  equals STATUS.timer_hit.
- bus_err  out  1  equals STATUS.bus_err.

## Operation
- Decode on ram_address[31:28]:
  - 0x0 selects RAM, word index ram_address[log2(DEPTH)+1:2].
  - 0x1 selects MMIO, offset ram_address[7:0].
  - Anything else is unmapped.
- Error condition: unmapped, misaligned (ram_address[1:0] != 0), RAM address with ram_address[27:log2(DEPTH)+2] != 0, or an undefined MMIO offset.
  - Reads under the error condition return 0 and do not set bus_err.
  - Writes under the error condition are dropped and set bus_err.
- MMIO map (offsets):
  - 0x00 GPIO_OUT, rw, low GPIO_W bits.
  - 0x04 CYCLE_LO, ro.
  - 0x08 CYCLE_HI, ro.
  - 0x0C TIMER_CMP, rw.
  - 0x10 STATUS, bit0 timer_hit, bit1 bus_err; write-1-to-clear.
  - 0x14 TIMER_CTRL, bit0 enable, rw.
  - 0x18 TIMER_CNT, ro.
  - Writes to read-only offsets are ignored and are not errors.
- Cycle counter: 64-bit, increments every cycle, wraps to 0.
- Timer:
  - Counts only while enable=1.
  - When enable=1 and TIMER_CNT == TIMER_CMP: next cycle TIMER_CNT=0 and timer_hit=1. Otherwise TIMER_CNT increments.
  - With TIMER_CMP=0 and enable=1, timer_hit asserts every cycle.
  - A write to TIMER_CMP also clears TIMER_CNT to 0.
  - Clearing enable freezes TIMER_CNT.

## Timing
- Reads: combinational from ram_address; zero latency. The core registers ram_r_data into MEM/WB.
- Writes: take effect on the rising clock edge where read_write_ram_en=1. The new value is visible to reads in the following cycle.
- Read of an address being written in the same cycle returns the old value.
- Reset values:
  - ram_r_data follows the read decode.
  - gpio_out=0, timer_irq=0, bus_err=0.
  - Cycle counter=0; TIMER_CMP=0xFFFF_FFFF; TIMER_CNT=0; enable=0.
  - RAM contents are not reset.
- Reset asserted mid-operation: all registers above return to reset values on that edge. A concurrent write is dropped.
- Simultaneous events:
  - A hardware set of timer_hit or bus_err wins over a same-cycle W1C clear of that bit.
  - A write to TIMER_CMP in a match cycle: the CMP write wins, TIMER_CNT=0, and timer_hit is not set.
- CYCLE_HI/CYCLE_LO are not snapshotted. Software reads HI, LO, HI and retries on mismatch.

## Structure
- Shared package holds:
  - Region codes RGN_RAM=4'h0 and RGN_MMIO=4'h1.
  - MMIO offset constants OFS_GPIO … OFS_TCNT.
  - STATUS bit indices.
- One sub-module, mmio_timer: timer counter, compare, and timer_hit logic, with the CMP-write clear input. Keeps the top-level decode and RAM separate.
- RAM is an inferred register array with asynchronous read.

## Test plan
- RAM round trip:
  - Write 0xDEADBEEF to 0x0000_0010; next cycle read 0x0000_0010 → 0xDEADBEEF.
  - Same-cycle read at that address during a second write of 0x1 → 0xDEADBEEF.
- Error path:
  - Write to 0x0000_0012 → RAM unchanged, bus_err=1.
  - Write 0x2 to 0x1000_0010 → bus_err=0.
  - Read 0x2000_0000 → 0, bus_err stays 0.
- GPIO: write 0x1A5 to 0x1000_0000 → gpio_out=0xA5 (GPIO_W=8); read back returns 0x000000A5.
- Timer periodic:
  - CMP=3, enable=1 → timer_irq rises 4 cycles after enable and TIMER_CNT goes 0,1,2,3,0.
  - W1C 0x1 to STATUS in a non-match cycle → timer_irq=0.
  - W1C 0x1 coinciding with a match → timer_irq stays 1.
- Cycle counter: after reset release, reading CYCLE_LO at cycle N returns N; CYCLE_HI=0.
- Reset mid-run: enable timer, write GPIO, assert reset for 1 cycle → all outputs and registers at reset values; a RAM word written before reset keeps its value.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared decode constants for the data-memory responder: region codes,
// MMIO register offsets and STATUS bit positions.
package data_memory_responder_pkg;

  localparam logic [3:0] RGN_RAM  = 4'h0;
  localparam logic [3:0] RGN_MMIO = 4'h1;

  localparam logic [7:0] OFS_GPIO = 8'h00;
  localparam logic [7:0] OFS_CLO  = 8'h04;
  localparam logic [7:0] OFS_CHI  = 8'h08;
  localparam logic [7:0] OFS_TCMP = 8'h0C;
  localparam logic [7:0] OFS_STAT = 8'h10;
  localparam logic [7:0] OFS_TCTL = 8'h14;
  localparam logic [7:0] OFS_TCNT = 8'h18;

  localparam int STAT_HIT  = 0;
  localparam int STAT_BERR = 1;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/data_memory_responder_mmio_timer.sv
// Periodic compare timer: counter, compare register, enable and the sticky
// timer_hit flag with its write-1-to-clear input.
module mmio_timer
  import data_memory_responder_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        i_cmp_we,
  input  logic        i_ctl_we,
  input  logic        i_hit_clr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_cnt,
  output logic [31:0] o_cmp,
  output logic        o_en,
  output logic        o_hit
);

  logic [31:0] r_cnt;
  logic [31:0] r_cmp;
  logic        r_en;
  logic        r_hit;
  logic        w_match;

  // A CMP write in a match cycle suppresses the hit.
  assign w_match = r_en && (r_cnt == r_cmp) && !i_cmp_we;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_cmp <= TCMP_RST;
      r_en  <= 1'b0;
      r_hit <= 1'b0;
    end else begin
      if (i_cmp_we) begin
        r_cmp <= i_wdata;
        r_cnt <= '0;
      end else if (r_en) begin
        r_cnt <= w_match ? '0 : r_cnt + 32'd1;
      end
      if (i_ctl_we)
        r_en <= i_wdata[0];
      if (w_match)
        r_hit <= 1'b1;
      else if (i_hit_clr)
        r_hit <= 1'b0;
    end
  end

  assign o_cnt = r_cnt;
  assign o_cmp = r_cmp;
  assign o_en  = r_en;
  assign o_hit = r_hit;

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: word RAM with asynchronous read plus an MMIO window
// holding GPIO, a free-running 64-bit cycle counter, a timer and STATUS.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int GPIO_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       ram_address,
  input  logic [31:0]       ram_w_data,
  input  logic              read_write_ram_en,
  output logic [31:0]       ram_r_data,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq,
  output logic              bus_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]       r_mem [DEPTH];
  logic [GPIO_W-1:0] r_gpio;
  logic [63:0]       r_cyc;
  logic              r_berr;

  logic [3:0]        w_rgn;
  logic [7:0]        w_ofs;
  logic [AW-1:0]     w_idx;
  logic              w_aligned;
  logic              w_ram_sel;
  logic              w_mmio_sel;
  logic              w_err;
  logic              w_wr;
  logic              w_mmio_we;
  logic              w_stat_we;
  logic [31:0]       w_tcnt;
  logic [31:0]       w_tcmp;
  logic              w_ten;
  logic              w_hit;
  logic [31:0]       w_status;

  assign w_rgn      = ram_address[31:28];
  assign w_ofs      = ram_address[7:0];
  assign w_idx      = ram_address[AW+1:2];
  assign w_aligned  = (ram_address[1:0] == 2'b00);
  assign w_ram_sel  = (w_rgn == RGN_RAM) && w_aligned
                      && ((ram_address[27:0] >> (AW + 2)) == 28'd0);
  assign w_mmio_sel = (w_rgn == RGN_MMIO) && w_aligned
                      && (w_ofs inside {OFS_GPIO, OFS_CLO, OFS_CHI, OFS_TCMP,
                                        OFS_STAT, OFS_TCTL, OFS_TCNT});
  assign w_err      = !(w_ram_sel || w_mmio_sel);

  // Reset drops any concurrent write, including to the RAM.
  assign w_wr       = read_write_ram_en && !reset;
  assign w_mmio_we  = w_wr && w_mmio_sel;
  assign w_stat_we  = w_mmio_we && (w_ofs == OFS_STAT);

  always_ff @(posedge clock) begin
    if (w_wr && w_ram_sel)
      r_mem[w_idx] <= ram_w_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_gpio <= '0;
      r_cyc  <= '0;
      r_berr <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 64'd1;
      if (w_mmio_we && (w_ofs == OFS_GPIO))
        r_gpio <= ram_w_data[GPIO_W-1:0];
      if (read_write_ram_en && w_err)
        r_berr <= 1'b1;
      else if (w_stat_we && ram_w_data[STAT_BERR])
        r_berr <= 1'b0;
    end
  end

  mmio_timer u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_cmp_we  (w_mmio_we && (w_ofs == OFS_TCMP)),
    .i_ctl_we  (w_mmio_we && (w_ofs == OFS_TCTL)),
    .i_hit_clr (w_stat_we && ram_w_data[STAT_HIT]),
    .i_wdata   (ram_w_data),
    .o_cnt     (w_tcnt),
    .o_cmp     (w_tcmp),
    .o_en      (w_ten),
    .o_hit     (w_hit)
  );

  always_comb begin
    w_status            = '0;
    w_status[STAT_HIT]  = w_hit;
    w_status[STAT_BERR] = r_berr;
  end

  always_comb begin
    ram_r_data = '0;
    if (w_ram_sel) begin
      ram_r_data = r_mem[w_idx];
    end else if (w_mmio_sel) begin
      case (w_ofs)
        OFS_GPIO: ram_r_data = 32'(r_gpio);
        OFS_CLO:  ram_r_data = r_cyc[31:0];
        OFS_CHI:  ram_r_data = r_cyc[63:32];
        OFS_TCMP: ram_r_data = w_tcmp;
        OFS_STAT: ram_r_data = w_status;
        OFS_TCTL: ram_r_data = {31'd0, w_ten};
        OFS_TCNT: ram_r_data = w_tcnt;
        default:  ram_r_data = '0;
      endcase
    end
  end

  assign gpio_out  = r_gpio;
  assign timer_irq = w_hit;
  assign bus_err   = r_berr;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench: a driver issues one access per cycle and pushes the
// reference model's expected outputs; a monitor pops and compares them.
module tb_data_memory_responder;

  localparam int DEPTH = 1024;
  localparam int GW    = 8;

  logic          clock;
  logic          reset;
  logic [31:0]   ram_address;
  logic [31:0]   ram_w_data;
  logic          read_write_ram_en;
  logic [31:0]   ram_r_data;
  logic [GW-1:0] gpio_out;
  logic          timer_irq;
  logic          bus_err;

  data_memory_responder #(.DEPTH(DEPTH), .GPIO_W(GW)) dut (
    .clock             (clock),
    .reset             (reset),
    .ram_address       (ram_address),
    .ram_w_data        (ram_w_data),
    .read_write_ram_en (read_write_ram_en),
    .ram_r_data        (ram_r_data),
    .gpio_out          (gpio_out),
    .timer_irq         (timer_irq),
    .bus_err           (bus_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rd;
    bit          chk_rd;
    logic [31:0] gpio;
    logic        irq;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  bit [31:0]       m_mem [int unsigned];
  bit [GW-1:0]     m_gpio;
  longint unsigned m_cyc;
  bit [31:0]       m_cmp;
  bit [31:0]       m_cnt;
  bit              m_en;
  bit              m_hit;
  bit              m_berr;

  // 0 = RAM word, 1 = defined MMIO register, 2 = error
  function automatic int decode(input bit [31:0] a);
    bit [3:0] rgn;
    rgn = a[31:28];
    if (a % 4 != 0) return 2;
    if (rgn == 4'h0) return (a[27:0] < 4 * DEPTH) ? 0 : 2;
    if (rgn == 4'h1) return (a[7:0] <= 8'h18) ? 1 : 2;
    return 2;
  endfunction

  function automatic void model_read(input bit [31:0] a, output bit [31:0] rd,
                                     output bit chk);
    int unsigned idx;
    rd  = 0;
    chk = 1;
    case (decode(a))
      0: begin
        idx = a[27:2];
        if (m_mem.exists(idx)) rd = m_mem[idx];
        else chk = 0;
      end
      1: case (a[7:0])
        8'h00: rd = 32'(m_gpio);
        8'h04: rd = m_cyc[31:0];
        8'h08: rd = m_cyc[63:32];
        8'h0C: rd = m_cmp;
        8'h10: rd = {30'd0, m_berr, m_hit};
        8'h14: rd = {31'd0, m_en};
        8'h18: rd = m_cnt;
        default: rd = 0;
      endcase
      default: rd = 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_gpio = 0; m_cyc = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0;
    m_en = 0; m_hit = 0; m_berr = 0;
  endfunction

  function automatic void model_step(input bit rst, input bit [31:0] a,
                                     input bit [31:0] wd, input bit we);
    int k;
    bit [7:0] ofs;
    bit wm, hit_set;
    if (rst) begin
      model_reset();
      return;
    end
    k = decode(a);
    ofs = a[7:0];
    wm = we && (k == 1);
    hit_set = 0;
    if (wm && ofs == 8'h0C) begin
      m_cmp = wd;
      m_cnt = 0;
    end else if (m_en) begin
      if (m_cnt == m_cmp) begin
        m_cnt = 0;
        hit_set = 1;
      end else m_cnt = m_cnt + 1;
    end
    if (wm && ofs == 8'h14) m_en = wd[0];
    if (wm && ofs == 8'h00) m_gpio = wd[GW-1:0];
    if (wm && ofs == 8'h10) begin
      if (wd[0]) m_hit = 0;
      if (wd[1]) m_berr = 0;
    end
    if (hit_set) m_hit = 1;
    if (we && k == 2) m_berr = 1;
    if (we && k == 0) m_mem[a[27:2]] = wd;
    m_cyc = m_cyc + 1;
  endfunction

  task automatic drive(input bit rst, input bit [31:0] a, input bit [31:0] wd,
                       input bit we);
    exp_t e;
    bit [31:0] rd;
    bit chk;
    @(posedge clock);
    #1;
    reset             = rst;
    ram_address       = a;
    ram_w_data        = wd;
    read_write_ram_en = we;
    model_read(a, rd, chk);
    e.addr   = a;
    e.rd     = rd;
    e.chk_rd = chk;
    e.gpio   = 32'(m_gpio);
    e.irq    = m_hit;
    e.berr   = m_berr;
    sb_q.push_back(e);
    model_step(rst, a, wd, we);
  endtask

  task automatic check(input string nm, input logic [31:0] a,
                       input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @%h: got %h want %h", nm, a, act, want);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk_rd) check("rdata", e.addr, ram_r_data, e.rd);
      check("gpio", e.addr, 32'(gpio_out), e.gpio);
      check("timer_irq", e.addr, 32'(timer_irq), 32'(e.irq));
      check("bus_err", e.addr, 32'(bus_err), 32'(e.berr));
    end
  end

  function automatic bit [31:0] rand_addr();
    bit [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = 32'($urandom_range(0, 31)) << 2;
      4, 5, 6:    a = 32'h1000_0000 | (32'($urandom_range(0, 8)) << 2);
      7:          a = ($urandom_range(0, 1) ? 32'h1000_0000 : 32'h0)
                      | 32'($urandom_range(0, 31) << 2) | 32'($urandom_range(1, 3));
      8:          a = (32'($urandom_range(2, 15)) << 28) | ($urandom & 32'h0FFF_FFFC);
      default:    a = 32'h0000_1000 | ($urandom & 32'h0FFF_FFFC);
    endcase
    return a;
  endfunction

  initial begin
    bit [31:0] a, wd;
    model_reset();
    reset = 1'b1;
    ram_address = '0;
    ram_w_data = '0;
    read_write_ram_en = 1'b0;

    drive(1, 32'h0, 0, 0);
    drive(1, 32'h0, 0, 0);
    // cycle counter after release, and reset values of MMIO registers
    drive(0, 32'h1000_0004, 0, 0);
    drive(0, 32'h1000_0008, 0, 0);
    drive(0, 32'h1000_0004, 0, 0);
    drive(0, 32'h1000_000C, 0, 0);
    drive(0, 32'h1000_0014, 0, 0);
    drive(0, 32'h1000_0018, 0, 0);
    // RAM round trip and same-cycle read during write
    drive(0, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    drive(0, 32'h0000_0010, 0, 0);
    drive(0, 32'h0000_0010, 32'h1, 1);
    drive(0, 32'h0000_0010, 0, 0);
    drive(0, 32'h0000_0010, 32'hDEAD_BEEF, 1);
    // error path
    drive(0, 32'h0000_0012, 32'h5555_5555, 1);
    drive(0, 32'h0000_0010, 0, 0);
    drive(0, 32'h1000_0010, 32'h2, 1);
    drive(0, 32'h2000_0000, 0, 0);
    drive(0, 32'h1000_0010, 0, 0);
    drive(0, 32'h1000_0004, 32'h1234, 1);
    drive(0, 32'h1000_0020, 32'h1, 1);
    drive(0, 32'h1000_0010, 32'h2, 1);
    // GPIO
    drive(0, 32'h1000_0000, 32'h1A5, 1);
    drive(0, 32'h1000_0000, 0, 0);
    // periodic timer
    drive(0, 32'h1000_000C, 32'd3, 1);
    drive(0, 32'h1000_0014, 32'd1, 1);
    for (int i = 0; i < 10; i++) drive(0, 32'h1000_0018, 0, 0);
    for (int i = 0; i < 8 && (m_cnt == m_cmp); i++) drive(0, 32'h1000_0018, 0, 0);
    drive(0, 32'h1000_0010, 32'h1, 1);
    drive(0, 32'h1000_0010, 0, 0);
    for (int i = 0; i < 8 && !(m_en && m_cnt == m_cmp); i++) drive(0, 32'h1000_0018, 0, 0);
    drive(0, 32'h1000_0010, 32'h1, 1);
    drive(0, 32'h1000_0010, 0, 0);
    drive(0, 32'h1000_0010, 32'h1, 1);
    for (int i = 0; i < 8 && !(m_en && m_cnt == m_cmp); i++) drive(0, 32'h1000_0018, 0, 0);
    drive(0, 32'h1000_000C, 32'd2, 1);
    drive(0, 32'h1000_0010, 0, 0);
    drive(0, 32'h1000_0018, 0, 0);
    // CMP=0 hits every cycle
    drive(0, 32'h1000_000C, 32'd0, 1);
    for (int i = 0; i < 3; i++) drive(0, 32'h1000_0010, 32'h1, 1);
    // reset mid-run, with a concurrent write that must be dropped
    drive(0, 32'h0000_0020, 32'hCAFE_F00D, 1);
    drive(0, 32'h1000_0000, 32'h3C, 1);
    drive(0, 32'h0000_0024, 32'h0BAD_0BAD, 1);
    drive(1, 32'h0000_0020, 32'h1111_1111, 1);
    drive(0, 32'h0000_0020, 0, 0);
    drive(0, 32'h1000_0014, 0, 0);
    drive(0, 32'h1000_000C, 0, 0);
    drive(0, 32'h1000_0004, 0, 0);

    for (int i = 0; i < 800; i++) begin
      a  = rand_addr();
      wd = $urandom;
      if (a == 32'h1000_000C) wd = 32'($urandom_range(0, 6));
      drive(($urandom_range(0, 79) == 0), a, wd, bit'($urandom_range(0, 1)));
    end
    drive(0, 32'h0000_0010, 0, 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
